sumcheck_prover: RTL and testbench
==================================

SUMCHECK_PROVER -- requirements
Module: sumcheck_prover

Interface
REQ-001 The module SHALL have parameter UINT_WIDTH, default 32, field word width.
REQ-002 The module SHALL have parameter NUM_LAYERS, default 4, circuit depth.
REQ-003 The module SHALL have parameter NUM_BITS, default NUM_LAYERS-1, gate-label bits.
REQ-004 The module SHALL have parameter NUM_VARS, default 2*NUM_BITS, sumcheck variables; the table holds 2^NUM_VARS words.
REQ-005 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-high reset
  load_en  in  1  table write strobe
  load_addr  in  NUM_VARS  table write address
  load_data  in  UINT_WIDTH  table write data
  start  in  1  begin a proof, sampled in IDLE only
  abort  in  1  return to IDLE from any state
  sample_pts[3]  out  UINT_WIDTH each  round evaluations g(0), g(1), g(2)
  pts_valid  out  1  sample_pts valid for current round
  chal_valid  in  1  challenge strobe
  chal_bit  in  1  verifier random bit for current round
  round  out  NUM_VARS+1  current round index
  final_val  out  UINT_WIDTH  table word at fully bound address
  done  out  1  proof complete

Function
REQ-006 States SHALL be IDLE, ACCUM, PRESENT, FINAL.
REQ-007 Table writes SHALL commit at the clock edge only in IDLE; load_en in any other state SHALL be ignored.
REQ-008 IDLE with start=1 SHALL go to ACCUM with round=0, prefix cleared, accumulators zeroed, and pair index j=0.
REQ-009 If load_en and start occur in the same cycle, the write SHALL commit and be visible to the first ACCUM read.
REQ-010 Round r SHALL bind address bit NUM_VARS-1-r (MSB first). Prefix holds chal bits of rounds 0..r-1. k = NUM_VARS-r free bits remain.
REQ-011 Each ACCUM cycle SHALL add table[{prefix,0,j}] to s0 and table[{prefix,1,j}] to s1, with j spanning k-1 bits. It SHALL leave ACCUM for PRESENT after j = 2^(k-1)-1.
REQ-012 pts_valid SHALL rise exactly 2^(k-1) edges after the edge entering ACCUM, i.e. 32 for round 0 at defaults and 1 for the last round.
REQ-013 All sums SHALL wrap modulo 2^UINT_WIDTH. Output sample_pts[0]=s0, sample_pts[1]=s1, sample_pts[2]=2*s1-s0 (mod 2^UINT_WIDTH).
REQ-014 In PRESENT, pts_valid=1 and sample_pts and round SHALL be held stable until chal_valid=1.
REQ-015 On chal_valid in PRESENT, the module SHALL append chal_bit to prefix and increment round. It SHALL then enter ACCUM (round<NUM_VARS, j and accumulators cleared) or FINAL (round==NUM_VARS).
REQ-016 chal_valid outside PRESENT SHALL be ignored.
REQ-017 FINAL SHALL drive final_val=table[prefix] and done=1, holding both until start or abort returns it to IDLE. start from FINAL SHALL behave as REQ-008.
REQ-018 abort SHALL take priority over all other inputs: next state IDLE, pts_valid=0, done=0, table unchanged.
REQ-019 pts_valid and done SHALL be 0 in IDLE and ACCUM.

Reset
REQ-020 On rst=1 at a clock edge, the module SHALL go to IDLE with round=0, pts_valid=0, done=0, sample_pts all 0, final_val=0, prefix=0, j=0, and accumulators 0.
REQ-021 Reset SHALL take priority over abort, start and chal_valid. Table contents after reset SHALL be don't-care and need not be cleared.
REQ-022 Reset asserted mid-ACCUM or mid-PRESENT SHALL discard the proof entirely, with no output pulse afterward.

Structure
REQ-023 Package sumcheck_pkg SHALL hold the UINT_WIDTH, NUM_LAYERS, NUM_BITS and NUM_VARS defaults and the state enum shared with the verifier side.
REQ-024 There SHALL be one sub-module, sumcheck_accum: a paired modulo-2^UINT_WIDTH accumulator (clear, add-enable, s0/s1 outputs). Table storage and FSM SHALL stay in sumcheck_prover.

Verification
REQ-025 Table[i]=i, start. The bench SHALL see round 0 with pts_valid after 32 edges and sample_pts = 496, 1520, 2544.
REQ-026 Continuing, chal_bit=1. The bench SHALL see round 1 with s0=632, s1=888 after 16 edges. With all chal=1, it SHALL then see done=1, final_val=63, round=6.
REQ-027 All entries 0xFFFFFFFF. The bench SHALL see round 0 with s0=s1=0xFFFFFFE0 and sample_pts[2]=0xFFFFFFE0 (wrap).
REQ-028 load_en to addr 0 during ACCUM SHALL be ignored and the sums SHALL be unchanged. chal_valid during ACCUM SHALL not advance round.
REQ-029 rst or abort at ACCUM cycle 10 SHALL give IDLE next cycle with all outputs 0. A fresh start SHALL reproduce REQ-025 values.
REQ-030 load_en with start in the same cycle writing table[0]=100 SHALL give s0=596 in round 0.

Source files
------------

// File: rtl/sumcheck_pkg.sv
// rtl/sumcheck_pkg.sv - shared sumcheck parameter defaults and prover/verifier state encoding
package sumcheck_pkg;
    localparam int UINT_WIDTH_DEF = 32;
    localparam int NUM_LAYERS_DEF = 4;
    localparam int NUM_BITS_DEF   = NUM_LAYERS_DEF - 1;
    localparam int NUM_VARS_DEF   = 2 * NUM_BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_PRESENT = 2'd2,
        ST_FINAL   = 2'd3
    } state_t;
endpackage

// File: rtl/sumcheck_accum.sv
// rtl/sumcheck_accum.sv - paired wrapping accumulator holding the g(0)/g(1) partial sums
module sumcheck_accum #(
    parameter int UINT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_add_en,
    input  logic [UINT_WIDTH-1:0] i_a0,
    input  logic [UINT_WIDTH-1:0] i_a1,
    output logic [UINT_WIDTH-1:0] o_s0,
    output logic [UINT_WIDTH-1:0] o_s1
);
    logic [UINT_WIDTH-1:0] r_s0;
    logic [UINT_WIDTH-1:0] r_s1;

    // Clear wins over add so a new round never inherits the previous round's sums.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_s0 <= '0;
            r_s1 <= '0;
        end else if (i_add_en) begin
            r_s0 <= r_s0 + i_a0;
            r_s1 <= r_s1 + i_a1;
        end
    end

    assign o_s0 = r_s0;
    assign o_s1 = r_s1;
endmodule

// File: rtl/sumcheck_prover.sv
// rtl/sumcheck_prover.sv - sumcheck prover: table store, round FSM and per-round g(0)/g(1)/g(2) evaluation
module sumcheck_prover
    import sumcheck_pkg::*;
#(
    parameter int UINT_WIDTH = UINT_WIDTH_DEF,
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int NUM_BITS   = NUM_LAYERS - 1,
    parameter int NUM_VARS   = 2 * NUM_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [NUM_VARS-1:0]   load_addr,
    input  logic [UINT_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  abort,
    output logic [UINT_WIDTH-1:0] sample_pts [3],
    output logic                  pts_valid,
    input  logic                  chal_valid,
    input  logic                  chal_bit,
    output logic [NUM_VARS:0]     round,
    output logic [UINT_WIDTH-1:0] final_val,
    output logic                  done
);
    localparam int            RW         = NUM_VARS + 1;
    localparam int            DEPTH      = 1 << NUM_VARS;
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_VARS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [UINT_WIDTH-1:0] r_table [DEPTH];
    logic [NUM_VARS-1:0]   r_prefix;
    logic [NUM_VARS-1:0]   r_j;
    logic [RW-1:0]         r_round;

    logic [RW-1:0]         w_k;
    logic [NUM_VARS-1:0]   w_half;
    logic [NUM_VARS-1:0]   w_addr0;
    logic [NUM_VARS-1:0]   w_addr1;
    logic                  w_j_last;
    logic                  w_clear;
    logic                  w_acc_clr;
    logic                  w_acc_add;
    logic                  w_take_chal;
    logic [UINT_WIDTH-1:0] w_s0;
    logic [UINT_WIDTH-1:0] w_s1;
    logic                  w_present;
    logic                  w_final;

    always_ff @(posedge clk) begin
        if (!rst && !abort && load_en && r_state == ST_IDLE) begin
            r_table[load_addr] <= load_data;
        end
    end

    // Bound prefix sits above the k free bits; the bit being bound this round is the top free bit.
    assign w_k      = RW'(NUM_VARS) - r_round;
    assign w_half   = NUM_VARS'(1) << (w_k - RW'(1));
    assign w_addr0  = (r_prefix << w_k) | r_j;
    assign w_addr1  = w_addr0 | w_half;
    assign w_j_last = (r_j == (w_half - NUM_VARS'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_add   = 1'b0;
        w_take_chal = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
            w_acc_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_FINAL: begin
                    if (start) begin
                        w_state_nxt = ST_ACCUM;
                        w_clear     = 1'b1;
                        w_acc_clr   = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    w_acc_add = 1'b1;
                    if (w_j_last) begin
                        w_state_nxt = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (chal_valid) begin
                        w_take_chal = 1'b1;
                        w_acc_clr   = 1'b1;
                        w_state_nxt = (r_round == LAST_ROUND) ? ST_FINAL : ST_ACCUM;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_round  <= '0;
            r_prefix <= '0;
            r_j      <= '0;
        end else if (w_take_chal) begin
            r_round  <= r_round + RW'(1);
            r_prefix <= {r_prefix[NUM_VARS-2:0], chal_bit};
            r_j      <= '0;
        end else if (w_acc_add) begin
            r_j <= w_j_last ? '0 : r_j + NUM_VARS'(1);
        end
    end

    sumcheck_accum #(
        .UINT_WIDTH (UINT_WIDTH)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_acc_clr),
        .i_add_en (w_acc_add),
        .i_a0     (r_table[w_addr0]),
        .i_a1     (r_table[w_addr1]),
        .o_s0     (w_s0),
        .o_s1     (w_s1)
    );

    assign w_present     = (r_state == ST_PRESENT);
    assign w_final       = (r_state == ST_FINAL);
    assign pts_valid     = w_present;
    assign done          = w_final;
    assign round         = r_round;
    assign sample_pts[0] = w_present ? w_s0 : '0;
    assign sample_pts[1] = w_present ? w_s1 : '0;
    assign sample_pts[2] = w_present ? ((w_s1 << 1) - w_s0) : '0;
    assign final_val     = w_final ? r_table[r_prefix] : '0;
endmodule

// File: tb/tb_sumcheck_prover.sv
// tb/tb_sumcheck_prover.sv - scoreboard bench for sumcheck_prover with directed hand-computed vectors
module tb_sumcheck_prover;
    localparam int W  = 32;
    localparam int NV = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [NV-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          start;
    logic          abort;
    logic [W-1:0]  sample_pts [3];
    logic          pts_valid;
    logic          chal_valid;
    logic          chal_bit;
    logic [NV:0]   round;
    logic [W-1:0]  final_val;
    logic          done;

    sumcheck_prover dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .abort      (abort),
        .sample_pts (sample_pts),
        .pts_valid  (pts_valid),
        .chal_valid (chal_valid),
        .chal_bit   (chal_bit),
        .round      (round),
        .final_val  (final_val),
        .done       (done)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        int         rnd;
        longint     at;
        logic [W-1:0] p0;
        logic [W-1:0] p1;
        logic [W-1:0] p2;
    } exp_t;
    exp_t q[$];

    // Round evaluations for table[i]=i with every challenge bit = 1.
    localparam logic [W-1:0] S0 [6] = '{32'd496,  32'd632, 32'd412, 32'd230, 32'd121, 32'd62};
    localparam logic [W-1:0] S1 [6] = '{32'd1520, 32'd888, 32'd476, 32'd246, 32'd125, 32'd63};
    localparam logic [W-1:0] S2 [6] = '{32'd2544, 32'd1144, 32'd540, 32'd262, 32'd129, 32'd64};
    localparam int           LAT [6] = '{32, 16, 8, 4, 2, 1};

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic push(input bit d, input int r, input longint at,
                        input logic [W-1:0] p0, input logic [W-1:0] p1, input logic [W-1:0] p2);
        exp_t e;
        e.is_done = d; e.rnd = r; e.at = at; e.p0 = p0; e.p1 = p1; e.p2 = p2;
        q.push_back(e);
    endtask

    initial begin : monitor
        bit   prev_pv;
        bit   prev_done;
        exp_t e;
        prev_pv   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pts_valid && !prev_pv) begin
                check("pts_expected_pending", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("pts_kind", longint'(e.is_done), 0);
                    check("pts_latency", cyc, e.at);
                    check("pts_round", longint'(round), e.rnd);
                    check("pts_g0", longint'(sample_pts[0]), longint'(e.p0));
                    check("pts_g1", longint'(sample_pts[1]), longint'(e.p1));
                    check("pts_g2", longint'(sample_pts[2]), longint'(e.p2));
                end
            end
            if (done && !prev_done) begin
                check("done_expected_pending", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("done_kind", longint'(e.is_done), 1);
                    check("done_at", cyc, e.at);
                    check("done_round", longint'(round), e.rnd);
                    check("done_final_val", longint'(final_val), longint'(e.p0));
                end
            end
            prev_pv   = pts_valid;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_pts_valid"}, longint'(pts_valid), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_round"}, longint'(round), 0);
        check({tag, "_final_val"}, longint'(final_val), 0);
        for (int i = 0; i < 3; i++) check({tag, "_sample_pt"}, longint'(sample_pts[i]), 0);
    endtask

    task automatic load_table(input bit all_ones, input int first);
        for (int i = first; i < 64; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = NV'(i);
            load_data = all_ones ? 32'hFFFF_FFFF : W'(i);
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_start(output longint entry);
        @(negedge clk);
        start = 1'b1;
        tick();
        entry = cyc;
        start = 1'b0;
    endtask

    task automatic do_chal(input bit b, output longint entry);
        chal_valid = 1'b1;
        chal_bit   = b;
        tick();
        entry      = cyc;
        chal_valid = 1'b0;
    endtask

    task automatic wait_sig(input string nm, input bit want_done);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (want_done ? done : pts_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        longint entry;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0; chal_valid = 1'b0; chal_bit = 1'b0;
        repeat (3) tick();
        chk_idle("reset");
        rst = 1'b0;

        // Full proof, table[i]=i, all challenges 1.
        load_table(1'b0, 0);
        do_start(entry);
        push(0, 0, entry + LAT[0], S0[0], S1[0], S2[0]);
        for (int r = 0; r < 6; r++) begin
            wait_sig("pts", 1'b0);
            if (r == 0) begin
                repeat (3) @(negedge clk);
                check("hold_valid", longint'(pts_valid), 1);
                check("hold_round", longint'(round), 0);
                check("hold_g2", longint'(sample_pts[2]), 2544);
            end
            do_chal(1'b1, entry);
            if (r < 5) push(0, r + 1, entry + LAT[r + 1], S0[r + 1], S1[r + 1], S2[r + 1]);
            else       push(1, 6, entry, 32'd63, '0, '0);
        end
        wait_sig("done", 1'b1);
        repeat (3) @(negedge clk);
        check("done_hold", longint'(done), 1);
        check("final_hold", longint'(final_val), 63);
        check("final_round_hold", longint'(round), 6);

        // Restart from FINAL; writes and challenges during ACCUM are ignored.
        do_start(entry);
        push(0, 0, entry + 32, 32'd496, 32'd1520, 32'd2544);
        repeat (4) @(negedge clk);
        load_en = 1'b1; load_addr = '0; load_data = 32'd999;
        chal_valid = 1'b1; chal_bit = 1'b0;
        @(negedge clk);
        load_en = 1'b0; chal_valid = 1'b0;
        check("accum_chal_ignored_round", longint'(round), 0);
        check("accum_no_pts", longint'(pts_valid), 0);
        wait_sig("pts_ign", 1'b0);
        do_abort();
        chk_idle("abort_present");

        // Abort at ACCUM cycle 10, then a fresh start reproduces round 0.
        do_start(entry);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort_accum");
        repeat (40) @(negedge clk);
        do_start(entry);
        push(0, 0, entry + 32, 32'd496, 32'd1520, 32'd2544);
        wait_sig("pts_fresh", 1'b0);

        // Reset mid-PRESENT and mid-ACCUM discards the proof.
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_present");
        repeat (40) @(negedge clk);
        do_start(entry);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_accum");
        repeat (40) @(negedge clk);

        // Wrap: 32 * 0xFFFFFFFF mod 2^32.
        load_table(1'b1, 0);
        do_start(entry);
        push(0, 0, entry + 32, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_FFE0);
        wait_sig("pts_wrap", 1'b0);
        do_abort();

        // Write of table[0]=100 in the same cycle as start.
        load_table(1'b0, 1);
        @(negedge clk);
        load_en = 1'b1; load_addr = '0; load_data = 32'd100; start = 1'b1;
        tick();
        entry = cyc;
        load_en = 1'b0; start = 1'b0;
        push(0, 0, entry + 32, 32'd596, 32'd1520, 32'd2444);
        wait_sig("pts_ldstart", 1'b0);
        do_abort();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
